// File: rtl/banked_lane_mem_pkg.sv
// Shared definitions for the banked byte-lane memory: state encoding and width helpers.
package banked_lane_mem_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // log2 of a power-of-two count (0 for a count of 1)
  function automatic int unsigned log2_of(input int unsigned n);
    return $clog2(n);
  endfunction

  // Width of a select signal for n items; never zero so ports stay legal
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Cycles from request accept to rsp_valid
  function automatic int unsigned read_latency(input int unsigned out_reg);
    return 1 + out_reg;
  endfunction

endpackage

// File: rtl/banked_lane_mem_bank.sv
// One (LANES*8)-bit wide bank with per-lane write mask and registered read.
module banked_lane_mem_bank
  import banked_lane_mem_pkg::*;
#(
  parameter int unsigned LANES   = 2,
  parameter int unsigned DEPTH_W = 15
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic                      we,
  input  logic [LANES-1:0]          mask,
  input  logic [DEPTH_W-1:0]        addr,
  input  logic [LANES*BYTE_W-1:0]   wdata,
  output logic [LANES*BYTE_W-1:0]   rdata
);

  localparam int unsigned WORD_W = LANES * BYTE_W;

`ifdef ICE40
  localparam bit USE_SPRAM = (LANES == 2) && (DEPTH_W <= 14);
`else
  localparam bit USE_SPRAM = 1'b0;
`endif

  generate
    if (USE_SPRAM) begin : g_spram
`ifdef ICE40
      logic [3:0] nib_mask;
      assign nib_mask = {{2{mask[1]}}, {2{mask[0]}}};
      // 16K x 16 single-port RAM; nibble mask expands the byte-lane mask
      SB_SPRAM256KA u_spram (
        .ADDRESS    (14'(addr)),
        .DATAIN     (wdata),
        .MASKWREN   (nib_mask),
        .WREN       (we),
        .CHIPSELECT (en),
        .CLOCK      (clk),
        .STANDBY    (1'b0),
        .SLEEP      (1'b0),
        .POWEROFF   (1'b1),
        .DATAOUT    (rdata)
      );
`endif
    end else begin : g_infer
      logic [WORD_W-1:0] mem [2**DEPTH_W];

      // Masked write or registered read of the addressed word
      always_ff @(posedge clk) begin
        if (en) begin
          if (we) begin
            for (int l = 0; l < LANES; l++) begin
              if (mask[l]) begin
                mem[addr][l*BYTE_W +: BYTE_W] <= wdata[l*BYTE_W +: BYTE_W];
              end
            end
          end else begin
            rdata <= mem[addr];
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/banked_lane_mem.sv
// Byte-addressed banked memory: boot loader fills it, then the CPU request port owns it.
module banked_lane_mem
  import banked_lane_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned LANES    = 2,
  parameter int unsigned BANKS    = 2,
  parameter int unsigned OUT_REG  = 0,
  parameter int unsigned WRITABLE = 0
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              load_valid_i,
  input  logic [7:0]        load_data_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              loaded_o,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_address_i,
  input  logic [7:0]        req_data_i,
  output logic              rsp_valid_o,
  output logic [7:0]        rsp_data_o
);

  localparam int unsigned LANE_W  = log2_of(LANES);
  localparam int unsigned BANK_W  = log2_of(BANKS);
  localparam int unsigned LANE_SW = sel_w(LANES);
  localparam int unsigned BANK_SW = sel_w(BANKS);
  localparam int unsigned WORD_AW = ADDR_W - BANK_W - LANE_W;
  localparam int unsigned WORD_W  = LANES * BYTE_W;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   load_ptr;
  logic                load_fire;
  logic                req_fire;
  logic [ADDR_W-1:0]   mem_addr;
  logic [7:0]          mem_byte;
  logic                mem_we;
  logic                mem_re;
  logic [LANE_SW-1:0]  lane_sel;
  logic [BANK_SW-1:0]  bank_sel;
  logic [WORD_AW-1:0]  word_sel;
  logic [LANES-1:0]    lane_mask;
  logic [WORD_W-1:0]   wdata;
  logic [WORD_W-1:0]   bank_rdata [BANKS];
  logic                rd_valid_q;
  logic [LANE_SW-1:0]  lane_q;
  logic [BANK_SW-1:0]  bank_q;
  logic [7:0]          rd_byte;

  assign load_ready_o = (state == ST_LOAD);
  assign req_ready_o  = (state == ST_RUN);

  // Request mux: loader owns the array in LOAD, CPU in RUN; nothing commits while in reset
  always_comb begin
    load_fire = load_valid_i && (state == ST_LOAD) && reset_n_i;
    req_fire  = req_valid_i && (state == ST_RUN) && reset_n_i;
    mem_addr  = req_address_i;
    mem_byte  = req_data_i;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (state == ST_LOAD) begin
      mem_addr = load_ptr;
      mem_byte = load_data_i;
      mem_we   = load_fire;
    end else begin
      mem_we = req_fire && req_write_i && (WRITABLE != 0);
      mem_re = req_fire && !req_write_i;
    end
  end

  assign lane_sel  = LANE_SW'(mem_addr & ADDR_W'(LANES - 1));
  assign word_sel  = WORD_AW'(mem_addr >> LANE_W);
  assign bank_sel  = (BANK_W == 0) ? '0 : BANK_SW'(mem_addr >> (ADDR_W - BANK_W));
  assign lane_mask = LANES'(1) << lane_sel;
  assign wdata     = {LANES{mem_byte}};

  // State register
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next state: LOAD ends on the last byte or when the pointer reaches the top address
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD: begin
        if (load_fire && (load_last_i || (load_ptr == {ADDR_W{1'b1}}))) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_LOAD;
    endcase
  end

  // Load pointer and image-complete flag
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      load_ptr <= '0;
      loaded_o <= 1'b0;
    end else begin
      loaded_o <= (state_next == ST_RUN);
      if (load_fire) begin
        load_ptr <= load_ptr + ADDR_W'(1);
      end
    end
  end

  generate
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
      banked_lane_mem_bank #(
        .LANES   (LANES),
        .DEPTH_W (WORD_AW)
      ) u_bank (
        .clk   (clock_i),
        .en    ((mem_we || mem_re) && (bank_sel == BANK_SW'(b))),
        .we    (mem_we),
        .mask  (lane_mask),
        .addr  (word_sel),
        .wdata (wdata),
        .rdata (bank_rdata[b])
      );
    end
  endgenerate

  // Lane/bank tag travels with the read so the live address can move on
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      rd_valid_q <= 1'b0;
      lane_q     <= '0;
      bank_q     <= '0;
    end else begin
      rd_valid_q <= mem_re;
      if (mem_re) begin
        lane_q <= lane_sel;
        bank_q <= bank_sel;
      end
    end
  end

  assign rd_byte = bank_rdata[bank_q][{lane_q, 3'b000} +: 8];

  generate
    if (OUT_REG == 0) begin : g_direct
      logic [7:0] hold_q;

      // Keep the last returned byte so the output is stable between responses
      always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
          hold_q <= '0;
        end else if (rd_valid_q) begin
          hold_q <= rd_byte;
        end
      end

      assign rsp_valid_o = rd_valid_q;
      assign rsp_data_o  = rd_valid_q ? rd_byte : hold_q;
    end else begin : g_reg
      // Extra output stage; data only updates on a valid response
      always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
          rsp_valid_o <= 1'b0;
          rsp_data_o  <= '0;
        end else begin
          rsp_valid_o <= rd_valid_q;
          if (rd_valid_q) begin
            rsp_data_o <= rd_byte;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_banked_lane_mem.sv
// Randomised bench: a ROM instance (OUT_REG=0) and a RAM instance (OUT_REG=1) share stimulus
// and are checked against a flat byte-array model with cycle-stamped expected responses.
module tb_banked_lane_mem;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned NBYTES = 2**ADDR_W;

  logic              clock_i = 1'b0;
  logic              reset_n_i;
  logic              load_valid_i;
  logic [7:0]        load_data_i;
  logic              load_last_i;
  logic              req_valid_i;
  logic              req_write_i;
  logic [ADDR_W-1:0] req_address_i;
  logic [7:0]        req_data_i;

  logic       load_ready0, loaded0, req_ready0, rsp_valid0;
  logic [7:0] rsp_data0;
  logic       load_ready1, loaded1, req_ready1, rsp_valid1;
  logic [7:0] rsp_data1;

  always #5 clock_i = ~clock_i;

  banked_lane_mem #(.ADDR_W(ADDR_W), .LANES(2), .BANKS(2), .OUT_REG(0), .WRITABLE(0)) u_rom (
    .clock_i(clock_i), .reset_n_i(reset_n_i),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i), .load_last_i(load_last_i),
    .load_ready_o(load_ready0), .loaded_o(loaded0),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready0), .req_write_i(req_write_i),
    .req_address_i(req_address_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid0), .rsp_data_o(rsp_data0)
  );

  banked_lane_mem #(.ADDR_W(ADDR_W), .LANES(2), .BANKS(2), .OUT_REG(1), .WRITABLE(1)) u_ram (
    .clock_i(clock_i), .reset_n_i(reset_n_i),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i), .load_last_i(load_last_i),
    .load_ready_o(load_ready1), .loaded_o(loaded1),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready1), .req_write_i(req_write_i),
    .req_address_i(req_address_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid1), .rsp_data_o(rsp_data1)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte array per instance, run flag, load pointer, expected responses
  typedef struct packed {
    longint unsigned due;
    logic [7:0]      data;
  } exp_t;

  logic [7:0]      ref0 [NBYTES];
  logic [7:0]      ref1 [NBYTES];
  bit              m_run = 1'b0;
  int unsigned     m_ptr = 0;
  longint unsigned cyc   = 0;
  bit              mon_en = 1'b0;
  exp_t            q0[$];
  exp_t            q1[$];

  always @(posedge clock_i) begin
    if (!reset_n_i) begin
      m_run = 1'b0;
      m_ptr = 0;
      q0.delete();
      q1.delete();
    end else if (!m_run) begin
      if (load_valid_i) begin
        ref0[m_ptr] = load_data_i;
        ref1[m_ptr] = load_data_i;
        if (load_last_i || m_ptr == NBYTES - 1) m_run = 1'b1;
        m_ptr = (m_ptr + 1) % NBYTES;
      end
    end else if (req_valid_i) begin
      if (req_write_i) begin
        ref1[req_address_i] = req_data_i;
      end else begin
        q0.push_back('{due: cyc + 1, data: ref0[req_address_i]});
        q1.push_back('{due: cyc + 2, data: ref1[req_address_i]});
      end
    end
    cyc++;
  end

  always @(negedge clock_i) begin
    if (mon_en) begin
      check_eq("load_ready0", 32'(load_ready0), 32'(!m_run));
      check_eq("load_ready1", 32'(load_ready1), 32'(!m_run));
      check_eq("req_ready0", 32'(req_ready0), 32'(m_run));
      check_eq("req_ready1", 32'(req_ready1), 32'(m_run));
      check_eq("loaded0", 32'(loaded0), 32'(m_run));
      check_eq("loaded1", 32'(loaded1), 32'(m_run));
      if (q0.size() > 0 && q0[0].due == cyc) begin
        check_eq("rsp_valid0", 32'(rsp_valid0), 32'd1);
        check_eq("rsp_data0", 32'(rsp_data0), 32'(q0[0].data));
        void'(q0.pop_front());
      end else begin
        check_eq("rsp_valid0_idle", 32'(rsp_valid0), 32'd0);
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
        check_eq("rsp_valid1", 32'(rsp_valid1), 32'd1);
        check_eq("rsp_data1", 32'(rsp_data1), 32'(q1[0].data));
        void'(q1.pop_front());
      end else begin
        check_eq("rsp_valid1_idle", 32'(rsp_valid1), 32'd0);
      end
    end
  end

  task automatic idle();
    load_valid_i  = 1'b0;
    load_data_i   = 8'h00;
    load_last_i   = 1'b0;
    req_valid_i   = 1'b0;
    req_write_i   = 1'b0;
    req_address_i = '0;
    req_data_i    = 8'h00;
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
    idle();
  endtask

  task automatic reset_cycle();
    reset_n_i = 1'b0;
    step();
    reset_n_i = 1'b1;
  endtask

  task automatic load_byte(input logic [7:0] b, input logic last);
    load_valid_i = 1'b1;
    load_data_i  = b;
    load_last_i  = last;
    step();
  endtask

  task automatic read(input logic [ADDR_W-1:0] a);
    req_valid_i   = 1'b1;
    req_write_i   = 1'b0;
    req_address_i = a;
    step();
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    req_valid_i   = 1'b1;
    req_write_i   = 1'b1;
    req_address_i = a;
    req_data_i    = d;
    step();
  endtask

  initial begin
    logic [15:0] av;
    idle();
    reset_n_i = 1'b0;
    step();
    step();
    mon_en = 1'b1;
    check_eq("reset_rsp_data0", 32'(rsp_data0), 32'd0);
    check_eq("reset_rsp_data1", 32'(rsp_data1), 32'd0);
    check_eq("reset_rsp_valid1", 32'(rsp_valid1), 32'd0);
    reset_n_i = 1'b1;

    // Short image with last on the fourth byte, reads with random gaps
    load_byte(8'h11, 1'b0);
    load_byte(8'h22, 1'b0);
    load_byte(8'h33, 1'b0);
    load_byte(8'h44, 1'b1);
    for (int i = 0; i < 4; i++) begin
      read(ADDR_W'(i));
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (3) step();

    // Reset mid-load at ptr=2: the next byte must land at address 0
    reset_cycle();
    load_byte(8'hAA, 1'b0);
    load_byte(8'hBB, 1'b0);
    reset_cycle();
    load_byte(8'h5A, 1'b0);
    load_byte(8'h6B, 1'b0);
    load_byte(8'h7C, 1'b1);
    read(16'h0000);
    read(16'h0001);
    read(16'h0002);
    repeat (3) step();

    // Reset while a read is in flight: pending response must be dropped
    read(16'h0001);
    reset_cycle();
    repeat (3) step();
    load_byte(8'h3C, 1'b1);
    read(16'h0000);
    repeat (3) step();

    // Full image without last: RUN entered after the final byte
    reset_cycle();
    for (int a = 0; a < int'(NBYTES); a++) begin
      av = 16'(a);
      load_byte(av[7:0] ^ av[15:8], 1'b0);
    end
    read(16'h7FFF);
    step();
    read(16'h8000);
    repeat (3) step();
    check_eq("img_7fff", 32'(ref0[16'h7FFF]), 32'h80);
    check_eq("img_8000", 32'(ref0[16'h8000]), 32'h80);

    // Back-to-back reads crossing lanes and banks
    read(16'h0001);
    read(16'h8000);
    read(16'h0000);
    repeat (3) step();

    // Write then immediate reads of the byte and its lane neighbour
    write(16'h1235, 8'hA5);
    read(16'h1235);
    read(16'h1234);
    repeat (3) step();

    // RUN traffic with the loader port hammered by 0xFF
    for (int i = 0; i < 400; i++) begin
      load_valid_i = 1'($urandom_range(0, 1));
      load_data_i  = 8'hFF;
      load_last_i  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin
          req_valid_i = 1'b0;
        end
        1: begin
          req_valid_i   = 1'b1;
          req_write_i   = 1'b1;
          req_address_i = ADDR_W'($urandom);
          req_data_i    = 8'($urandom);
        end
        default: begin
          req_valid_i   = 1'b1;
          req_write_i   = 1'b0;
          req_address_i = ADDR_W'($urandom);
        end
      endcase
      step();
    end
    repeat (4) step();

    check_eq("q0_drained", 32'(q0.size()), 32'd0);
    check_eq("q1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
